// File: rtl/rom_burst_reader.sv
// rom_burst_reader: reads LEN+1 consecutive ROM words starting at BASE and
// streams them out through a 2-entry FIFO with DVALID/DREADY back-pressure.
module rom_burst_reader #(
  parameter int AW = 14,
  parameter int DW = 24
) (
  input  logic          CK,
  input  logic          RSTN,
  input  logic          START,
  input  logic [AW-1:0] BASE,
  input  logic [AW-1:0] LEN,
  output logic          BUSY,
  output logic          DONE,
  output logic [AW-1:0] ROM_A,
  output logic          ROM_OE,
  input  logic [DW-1:0] ROM_Q,
  output logic [DW-1:0] DOUT,
  output logic          DVALID,
  input  logic          DREADY,
  output logic          state_dbg
);

  // Stream handshake: a word moves on a rising CK edge where DVALID and DREADY
  // are both 1; once DVALID is raised, it and DOUT hold until that edge.

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t             state_q, state_d;
  logic [AW-1:0]      addr_q, addr_d, last_a_q, last_a_d, len_q, len_d;
  logic [AW:0]        issue_cnt_q, issue_cnt_d, accept_cnt_q, accept_cnt_d;
  logic [AW:0]        total;
  logic               inflight_q, inflight_d, done_q, done_d;
  logic [1:0][DW-1:0] mem_q, mem_d;
  logic               wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [1:0]         cnt_q, cnt_d, held;
  logic               accept_start, pop, issue, last_xfer;

  assign total = {1'b0, len_q} + (AW + 1)'(1);

  always_ff @(posedge CK or negedge RSTN) begin
    if (!RSTN) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept_start) state_d = RUN;
      RUN:     if (last_xfer)    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Words still owed to the consumer after this cycle's transfer (FIFO plus
  // the read whose data is on ROM_Q now) must leave room for one more read.
  always_comb begin
    accept_start = (state_q == IDLE) && START && !done_q;
    pop          = (cnt_q != 2'd0) && DREADY;
    held         = cnt_q - {1'b0, pop} + {1'b0, inflight_q};
    issue        = (state_q == RUN) && (issue_cnt_q != total) && (held < 2'd2);
    last_xfer    = (state_q == RUN) && pop && (accept_cnt_q == {1'b0, len_q});
    BUSY         = (state_q == RUN);
    DONE         = done_q;
    ROM_OE       = issue;
    ROM_A        = issue ? addr_q : last_a_q;
    DVALID       = (cnt_q != 2'd0);
    DOUT         = mem_q[rd_ptr_q];
    state_dbg    = (state_q == RUN);
  end

  always_comb begin
    addr_d       = addr_q;
    last_a_d     = last_a_q;
    len_d        = len_q;
    issue_cnt_d  = issue_cnt_q;
    accept_cnt_d = accept_cnt_q;
    mem_d        = mem_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    done_d       = last_xfer;
    inflight_d   = issue;
    cnt_d        = cnt_q + {1'b0, inflight_q} - {1'b0, pop};
    if (accept_start) begin
      addr_d       = BASE;
      len_d        = LEN;
      issue_cnt_d  = '0;
      accept_cnt_d = '0;
    end
    if (issue) begin
      addr_d      = addr_q + 1'b1;
      last_a_d    = addr_q;
      issue_cnt_d = issue_cnt_q + 1'b1;
    end
    // ROM data is valid exactly one cycle after the read was presented.
    if (inflight_q) begin
      mem_d[wr_ptr_q] = ROM_Q;
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d     = ~rd_ptr_q;
      accept_cnt_d = accept_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge CK or negedge RSTN) begin
    if (!RSTN) begin
      addr_q       <= '0;
      last_a_q     <= '0;
      len_q        <= '0;
      issue_cnt_q  <= '0;
      accept_cnt_q <= '0;
      mem_q        <= '0;
      wr_ptr_q     <= 1'b0;
      rd_ptr_q     <= 1'b0;
      done_q       <= 1'b0;
      inflight_q   <= 1'b0;
      cnt_q        <= 2'd0;
    end else begin
      addr_q       <= addr_d;
      last_a_q     <= last_a_d;
      len_q        <= len_d;
      issue_cnt_q  <= issue_cnt_d;
      accept_cnt_q <= accept_cnt_d;
      mem_q        <= mem_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      done_q       <= done_d;
      inflight_q   <= inflight_d;
      cnt_q        <= cnt_d;
    end
  end

endmodule

// File: tb/tb_rom_burst_reader.sv
// Bench for rom_burst_reader: ROM model returns the read address, a
// scoreboard expects BASE..BASE+LEN (mod 2^AW) in order for every burst.
module tb_rom_burst_reader;
  localparam int AW = 14;
  localparam int DW = 24;

  logic          CK = 1'b0;
  logic          RSTN, START, DREADY, BUSY, DONE, ROM_OE, DVALID, state_dbg;
  logic [AW-1:0] BASE, LEN, ROM_A;
  logic [DW-1:0] ROM_Q, DOUT;

  rom_burst_reader #(.AW(AW), .DW(DW)) dut (
    .CK(CK), .RSTN(RSTN), .START(START), .BASE(BASE), .LEN(LEN),
    .BUSY(BUSY), .DONE(DONE), .ROM_A(ROM_A), .ROM_OE(ROM_OE), .ROM_Q(ROM_Q),
    .DOUT(DOUT), .DVALID(DVALID), .DREADY(DREADY), .state_dbg(state_dbg)
  );

  // ---- clock / reset / cycle count
  always #5 CK = ~CK;
  int cyc = 0;
  always @(posedge CK) cyc <= cyc + 1;

  // ---- ROM model: Q is the address presented one edge earlier, junk otherwise
  always @(posedge CK) begin
    if (ROM_OE) ROM_Q <= DW'(ROM_A);
    else        ROM_Q <= DW'($urandom);
  end

  // ---- counters and scoreboard
  int errors = 0;
  int checks = 0;
  logic [DW-1:0] exp_q[$];
  logic [AW-1:0] exp_addr = '0;
  int  rdy_mode = 0;
  int  start_cyc = 0;
  bit  mon_on = 1'b0;
  int  issued = 0, xfers = 0, done_seen = 0, vld_rise_cyc = -1;
  logic [DW-1:0] last_word = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: at cycle %0d", name, cyc);
  endtask

  // ---- DREADY driver: 0 = always ready, 1 = 1,0,0 pattern, else random
  always @(posedge CK) begin
    #1;
    case (rdy_mode)
      0:       DREADY = 1'b1;
      1:       DREADY = ((cyc - start_cyc) % 3 == 0);
      default: DREADY = 1'($urandom_range(0, 1));
    endcase
  end

  // ---- monitor: sampled on the falling edge
  bit            prev_stall = 0, prev_vld = 0, last_prev = 0;
  logic [DW-1:0] prev_dout = '0;
  always @(negedge CK) begin
    if (mon_on && RSTN) begin
      automatic bit pop_now = DVALID && DREADY;
      automatic int outstanding = issued - xfers;
      if (prev_stall) begin
        check("stall_dvalid", DVALID, 1);
        check("stall_dout", DOUT, prev_dout);
      end
      if (last_prev) begin
        check("done_after_last", DONE, 1);
        check("busy_after_last", BUSY, 0);
      end
      last_prev = 0;
      if (DONE) done_seen++;
      if (!BUSY) check("oe_when_idle", ROM_OE, 0);
      if (DVALID && !prev_vld && vld_rise_cyc < start_cyc) vld_rise_cyc = cyc;
      if (outstanding - int'(pop_now) >= 2) check("oe_credit", ROM_OE, 0);
      if (ROM_OE) begin
        check("rom_addr", ROM_A, exp_addr);
        exp_addr = exp_addr + 1'b1;
        issued++;
      end
      if (pop_now) begin
        if (exp_q.size() == 0) fail("unexpected_word");
        else begin
          check("dout", DOUT, exp_q.pop_front());
          if (exp_q.size() == 0) last_prev = 1;
        end
        xfers++;
        last_word = DOUT;
      end
      prev_stall = DVALID && !DREADY;
      prev_dout  = DOUT;
      prev_vld   = DVALID;
    end else begin
      prev_stall = 0;
      prev_vld   = 0;
      last_prev  = 0;
      issued     = xfers;
    end
  end

  // ---- driver tasks
  task automatic launch(input logic [AW-1:0] base, input logic [AW-1:0] len, input int mode);
    logic [AW-1:0] a;
    @(posedge CK); #1;
    rdy_mode = mode;
    for (int i = 0; i <= int'(len); i++) begin
      a = base + AW'(i);
      exp_q.push_back(DW'(a));
    end
    exp_addr = base;
    BASE = base; LEN = len; START = 1'b1;
    @(posedge CK); #1;
    start_cyc = cyc;
    START = 1'b0;
    BASE = AW'($urandom);
    LEN  = AW'($urandom);
  endtask

  task automatic finish_burst(input logic [AW-1:0] len, input bit poke,
                              input int x0, input int i0, input int d0, output int done_k);
    automatic int lim = 100 + 8 * (int'(len) + 1);
    automatic bit got = 0;
    done_k = -1;
    for (int n = 0; n < lim && !got; n++) begin
      @(posedge CK); #1;
      if (poke) begin
        START = ((cyc - start_cyc) == 3) || ((cyc - start_cyc) == 4);
        BASE  = AW'(50);
      end
      if (DONE) begin
        got = 1;
        done_k = cyc - start_cyc;
        START = poke;
      end
    end
    if (!got) fail("done_timeout");
    @(posedge CK); #1;
    START = 1'b0;
    check("done_one_pulse", DONE, 0);
    check("busy_after_done", BUSY, 0);
    @(posedge CK); #1;
    check("start_ignored", BUSY, 0);
    check("words_delivered", xfers - x0, int'(len) + 1);
    check("reads_issued", issued - i0, int'(len) + 1);
    check("done_count", done_seen - d0, 1);
    check("scoreboard_empty", exp_q.size(), 0);
    check("first_dvalid_cycle", vld_rise_cyc - start_cyc, 2);
  endtask

  // ---- stimulus table
  typedef struct {
    logic [AW-1:0] base;
    logic [AW-1:0] len;
    int            mode;
    bit            poke;
    logic [31:0]   exp_last;
    int            exp_done_k;
  } vec_t;
  vec_t tv[5];

  initial begin
    int x0, i0, d0, dk;
    logic [AW-1:0] b, l, e;
    tv[0] = '{14'd10,    14'd0,  0, 1'b0, 32'h0000000A, 3};
    tv[1] = '{14'd16368, 14'd15, 0, 1'b0, 32'd16383,    18};
    tv[2] = '{14'd16382, 14'd3,  0, 1'b0, 32'd1,        6};
    tv[3] = '{14'd100,   14'd7,  1, 1'b0, 32'd107,      -1};
    tv[4] = '{14'd20,    14'd3,  0, 1'b1, 32'd23,       6};

    RSTN = 1'b0; START = 1'b0; BASE = '0; LEN = '0; DREADY = 1'b1;
    repeat (3) @(posedge CK);
    #1;
    check("rst_busy", BUSY, 0);
    check("rst_done", DONE, 0);
    check("rst_dvalid", DVALID, 0);
    check("rst_rom_oe", ROM_OE, 0);
    check("rst_rom_a", ROM_A, 0);
    check("rst_dout", DOUT, 0);
    RSTN = 1'b1;
    @(posedge CK); #1;
    mon_on = 1'b1;

    for (int v = 0; v < 5; v++) begin
      x0 = xfers; i0 = issued; d0 = done_seen;
      launch(tv[v].base, tv[v].len, tv[v].mode);
      finish_burst(tv[v].len, tv[v].poke, x0, i0, d0, dk);
      check("last_word", last_word, tv[v].exp_last);
      if (tv[v].exp_done_k >= 0) check("done_cycle", dk, tv[v].exp_done_k);
    end

    // Reset in the middle of a burst, then a clean short burst.
    x0 = xfers;
    launch(14'd0, 14'd15, 0);
    begin
      automatic bit got = 0;
      for (int n = 0; n < 50 && !got; n++) begin
        @(posedge CK); #1;
        if (xfers - x0 >= 5) got = 1;
      end
      if (!got) fail("midburst_timeout");
    end
    mon_on = 1'b0;
    RSTN = 1'b0;
    #1;
    check("arst_busy", BUSY, 0);
    check("arst_done", DONE, 0);
    check("arst_dvalid", DVALID, 0);
    check("arst_rom_oe", ROM_OE, 0);
    check("arst_rom_a", ROM_A, 0);
    check("arst_dout", DOUT, 0);
    exp_q.delete();
    @(posedge CK); #1;
    RSTN = 1'b1;
    mon_on = 1'b1;
    x0 = xfers; i0 = issued; d0 = done_seen;
    launch(14'd200, 14'd1, 0);
    finish_burst(14'd1, 1'b0, x0, i0, d0, dk);
    check("post_reset_last", last_word, 32'd201);
    check("post_reset_done_cycle", dk, 4);

    // Random bursts under random back-pressure.
    for (int r = 0; r < 8; r++) begin
      b = AW'($urandom);
      l = (r == 7) ? AW'(60) : AW'($urandom_range(0, 12));
      e = b + l;
      x0 = xfers; i0 = issued; d0 = done_seen;
      launch(b, l, 2);
      finish_burst(l, 1'b0, x0, i0, d0, dk);
      check("rand_last_word", last_word, DW'(e));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/rom_burst_reader.md
ROM_BURST_READER -- requirements
Module: rom_burst_reader

Interface
REQ-001 SHALL have parameter AW, default 14, ROM address width.
REQ-002 SHALL have parameter DW, default 24, ROM data width.
REQ-003 SHALL have one clock and an asynchronous, active-low reset; no other clock or reset ports.
REQ-004 CK  input  1  single clock; all state updates on rising edge.
REQ-005 RSTN  input  1  asynchronous active-low reset.
REQ-006 START  input  1  burst request; sampled only in IDLE.
REQ-007 BASE  input  AW  first word address, sampled with START.
REQ-008 LEN  input  AW  burst length minus one (0 = 1 word, 2^AW-1 = 2^AW words), sampled with START.
REQ-009 BUSY  output  1  high from the cycle after an accepted START until the last word is accepted.
REQ-010 DONE  output  1  one-cycle pulse after the last word is accepted.
REQ-011 ROM_A  output  AW  address to ROM A port.
REQ-012 ROM_OE  output  1  read enable to ROM OE port.
REQ-013 ROM_Q  input  DW  ROM Q port.
REQ-014 DOUT  output  DW  stream data.
REQ-015 DVALID  output  1  DOUT valid.
REQ-016 DREADY  input  1  consumer ready; a word transfers on a rising edge with DVALID=1 and DREADY=1.

Function
REQ-017 ROM timing is fixed: the ROM samples A/OE at edge t; Q is valid after edge t+1 only when OE was 1 at t; the reader SHALL capture ROM_Q exactly one cycle after each issued read.
REQ-018 States SHALL be IDLE and RUN; IDLE->RUN on START=1; RUN->IDLE on the cycle the last word transfers; DONE=1 for the cycle after that transfer.
REQ-019 START while BUSY=1 or DONE=1 SHALL be ignored; BASE/LEN changes during RUN SHALL have no effect.
REQ-020 Internal address counter SHALL load BASE on START and increment by one per issued read, wrapping 2^AW-1 -> 0.
REQ-021 Issue counter and accept counter SHALL each be AW+1 bits; reads issued SHALL total exactly LEN+1, and ROM_OE SHALL be 0 once they are exhausted.
REQ-022 Output buffer SHALL be a 2-entry FIFO; a read SHALL be issued only when (FIFO occupancy + reads in flight) < 2, so no ROM word is ever dropped.
REQ-023 With DREADY held 1, throughput SHALL be one word per cycle after initial latency; first DVALID SHALL appear 2 cycles after the START edge.
REQ-024 Words SHALL leave in address order with no loss or duplication under any DREADY pattern.
REQ-025 DVALID SHALL stay 1 and DOUT SHALL stay stable while DREADY=0.
REQ-026 ROM_A SHALL hold its last value when ROM_OE=0; in IDLE, ROM_OE=0.

Reset
REQ-027 RSTN=0 SHALL immediately force IDLE with BUSY=0, DONE=0, DVALID=0, ROM_OE=0, ROM_A=0, DOUT=0; FIFO and counters clear.
REQ-028 Reset mid-burst SHALL discard all pending and in-flight words; after RSTN rises, the next START SHALL run a clean burst.

Verification (ROM model: ROM_Q = zero-extended address of issued read)
REQ-029 BASE=10, LEN=0, DREADY=1 -> one word 24'h00000A; DONE pulses the cycle after transfer; ROM_OE high for exactly 1 cycle.
REQ-030 BASE=16368, LEN=15, DREADY=1 -> 16 words 16368..16383 on consecutive cycles; BUSY falls and DONE pulses after the 16th.
REQ-031 BASE=16382, LEN=3 -> words 16382, 16383, 0, 1 (wrap-around).
REQ-032 BASE=100, LEN=7, DREADY toggling 1,0,0,1,0,... -> exactly 100..107 in order; ROM_OE=0 whenever FIFO+in-flight=2; DOUT stable while stalled.
REQ-033 BASE=0, LEN=15, RSTN low after 5 words for 1 cycle -> all outputs zero asynchronously; then START BASE=200, LEN=1 -> words 200, 201 only.
REQ-034 START with BASE=50 pulsed during a RUN burst from BASE=20, LEN=3 -> only 20..23 delivered; a single DONE.
